seven_segment_reader: RTL and testbench

- Receive-side counterpart of the seven-segment seconds display driver.
- Samples a 7-bit segment bus, from pads or a loopback of the driver's output, and synchronizes and de-glitches it.
- Decodes the pattern back to a decimal digit and measures the clock-cycle interval between successive digit changes.
- Sits in the user project next to the driver so firmware or the logic analyzer can check display timing and encoding on-chip.

---
 rtl/seven_segment_reader.sv | 149 ++++++++++++++
 tb/tb_seven_segment_reader.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_segment_reader.sv
// Seven-segment reader: synchronizes and de-glitches a segment bus, decodes it
// back to a decimal digit and measures the cycle interval between successive
// valid digit changes.
module seven_segment_reader #(
   parameter int STABLE_CYCLES = 4,   // 1..15
   parameter int CNT_W         = 24,
   parameter bit ACTIVE_LOW    = 1'b0
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_i,
   input  logic [6:0]       seg_in,
   input  logic             enable,
   input  logic             clear,
   output logic [3:0]       digit_o,
   output logic             digit_valid_o,
   output logic             change_o,
   output logic [CNT_W-1:0] interval_o,
   output logic             interval_valid_o,
   output logic [15:0]      change_count_o,
   output logic             invalid_o,
   output logic             overflow_o
);

   typedef enum logic [1:0] {PAT_DIGIT, PAT_BLANK, PAT_BAD} pat_kind_e;

   localparam logic [3:0]       STABLE  = 4'(STABLE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [6:0]       sync_q1, sync_q2;
   logic [6:0]       sync_val;
   logic [6:0]       cand, committed;
   logic [3:0]       stab, stab_next;
   logic             accept, valid_change;
   pat_kind_e        kind;
   logic [3:0]       dec_digit;
   logic [CNT_W-1:0] cnt;

   // Polarity correction happens after the synchronizer so both flops see raw pad data.
   assign sync_val = sync_q2 ^ {7{ACTIVE_LOW}};

   // Two-flop synchronizer; deliberately ignores enable and clear.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         sync_q1 <= '0;
         sync_q2 <= '0;
      end else begin
         sync_q1 <= seg_in;
         sync_q2 <= sync_q1;
      end
   end

   // Stability count this edge would produce, and whether the held pattern is accepted.
   // NOTE: every output of a combinational block gets a default first so no latch is inferred.
   always_comb begin
      stab_next = 4'd1;
      if (sync_val == cand)
         stab_next = (stab >= STABLE) ? STABLE : stab + 4'd1;
      accept = enable && (stab_next >= STABLE) && (sync_val != committed);
   end

   // Classify the pattern being accepted (g..a in bits 6..0).
   always_comb begin
      kind      = PAT_BAD;
      dec_digit = 4'd0;
      case (sync_val)
         7'h3F: begin kind = PAT_DIGIT; dec_digit = 4'd0; end
         7'h06: begin kind = PAT_DIGIT; dec_digit = 4'd1; end
         7'h5B: begin kind = PAT_DIGIT; dec_digit = 4'd2; end
         7'h4F: begin kind = PAT_DIGIT; dec_digit = 4'd3; end
         7'h66: begin kind = PAT_DIGIT; dec_digit = 4'd4; end
         7'h6D: begin kind = PAT_DIGIT; dec_digit = 4'd5; end
         7'h7D: begin kind = PAT_DIGIT; dec_digit = 4'd6; end
         7'h07: begin kind = PAT_DIGIT; dec_digit = 4'd7; end
         7'h7F: begin kind = PAT_DIGIT; dec_digit = 4'd8; end
         7'h6F: begin kind = PAT_DIGIT; dec_digit = 4'd9; end
         7'h00: kind = PAT_BLANK;
         default: kind = PAT_BAD;
      endcase
   end

   assign valid_change = accept && (kind == PAT_DIGIT);

   // Candidate tracker; disabling zeroes the count so the hold restarts on re-enable.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i || clear) begin
         cand <= '0;
         stab <= '0;
      end else if (!enable) begin
         stab <= '0;
      end else begin
         cand <= sync_val;
         stab <= stab_next;
      end
   end

   // Commit accepted patterns and update the digit-facing outputs.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i || clear) begin
         committed      <= '0;
         digit_o        <= '0;
         digit_valid_o  <= 1'b0;
         change_o       <= 1'b0;
         change_count_o <= '0;
         invalid_o      <= 1'b0;
      end else begin
         change_o <= 1'b0;
         if (accept) begin
            committed <= sync_val;
            case (kind)
               PAT_DIGIT: begin
                  digit_o        <= dec_digit;
                  digit_valid_o  <= 1'b1;
                  change_o       <= 1'b1;
                  change_count_o <= change_count_o + 16'd1;
               end
               PAT_BLANK: digit_valid_o <= 1'b0;
               default: begin
                  digit_valid_o <= 1'b0;
                  invalid_o     <= 1'b1;
               end
            endcase
         end
      end
   end

   // Interval counter: idle at 0 until the first valid change, then saturating.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i || clear) begin
         cnt              <= '0;
         interval_o       <= '0;
         interval_valid_o <= 1'b0;
         overflow_o       <= 1'b0;
      end else if (enable) begin
         if (valid_change) begin
            interval_o <= cnt;
            if (cnt != '0)
               interval_valid_o <= 1'b1;
            cnt <= CNT_ONE;
         end else if (cnt != '0 && cnt != CNT_MAX) begin
            cnt <= cnt + CNT_ONE;
            if (cnt == CNT_MAX - CNT_ONE)
               overflow_o <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_seven_segment_reader.sv
// Bench for seven_segment_reader: table vectors, directed timing sequences and
// a randomized run against a queue-based reference model.
module tb_seven_segment_reader;

   localparam int S = 4;

   logic        clk = 1'b0;
   logic        rst, enable, clear;
   logic [6:0]  seg;

   logic [3:0]  digit;
   logic        dvalid, change, ivalid, inv, ovf;
   logic [23:0] interval;
   logic [15:0] count;

   logic [3:0]  s_digit;
   logic        s_dvalid, s_change, s_ivalid, s_inv, s_ovf;
   logic [7:0]  s_interval;
   logic [15:0] s_count;

   int n_pass = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   seven_segment_reader #(.STABLE_CYCLES(S), .CNT_W(24), .ACTIVE_LOW(1'b0)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst), .seg_in(seg), .enable(enable), .clear(clear),
      .digit_o(digit), .digit_valid_o(dvalid), .change_o(change),
      .interval_o(interval), .interval_valid_o(ivalid), .change_count_o(count),
      .invalid_o(inv), .overflow_o(ovf));

   seven_segment_reader #(.STABLE_CYCLES(S), .CNT_W(8), .ACTIVE_LOW(1'b0)) dut_small (
      .wb_clk_i(clk), .wb_rst_i(rst), .seg_in(seg), .enable(enable), .clear(clear),
      .digit_o(s_digit), .digit_valid_o(s_dvalid), .change_o(s_change),
      .interval_o(s_interval), .interval_valid_o(s_ivalid), .change_count_o(s_count),
      .invalid_o(s_inv), .overflow_o(s_ovf));

   logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

   function automatic int decode(input logic [6:0] p);
      for (int i = 0; i < 10; i++)
         if (seg_tab[i] == p) return i;
      return -1;
   endfunction

   // ---------------- reference model ----------------
   // A pattern is accepted once the last S enabled, uncleared samples are
   // identical and differ from the committed one.
   localparam logic [23:0] M_MAX = 24'hFFFFFF;
   logic [6:0]  m_s1, m_s2, m_comm;
   logic [6:0]  m_q[$];
   logic [3:0]  m_digit;
   logic        m_dvalid, m_change, m_ivalid, m_inv, m_ovf;
   logic [23:0] m_interval, m_cnt;
   logic [15:0] m_count;

   task automatic model_zero(input bit with_sync);
      if (with_sync) begin m_s1 = '0; m_s2 = '0; end
      m_q.delete();
      m_comm = '0; m_digit = '0; m_dvalid = 0; m_change = 0; m_ivalid = 0;
      m_inv = 0; m_ovf = 0; m_interval = '0; m_cnt = '0; m_count = '0;
   endtask

   always @(posedge clk) begin
      logic [6:0] v;
      int d;
      bit acc;
      if (rst) model_zero(1);
      else begin
         v = m_s2; m_s2 = m_s1; m_s1 = seg;
         if (clear) model_zero(0);
         else if (!enable) begin
            m_q.delete();
            m_change = 0;
         end else begin
            m_change = 0;
            if (m_q.size() != 0 && m_q[$] != v) m_q.delete();
            m_q.push_back(v);
            if (m_q.size() > S) void'(m_q.pop_front());
            acc = (m_q.size() >= S) && (v != m_comm);
            d = decode(v);
            if (acc) begin
               m_comm = v;
               if (d < 0) begin
                  m_dvalid = 0;
                  if (v != 7'h00) m_inv = 1;
               end
            end
            if (acc && d >= 0) begin
               m_interval = m_cnt;
               if (m_cnt != 0) m_ivalid = 1;
               m_cnt = 24'd1;
               m_digit = 4'(d);
               m_dvalid = 1;
               m_change = 1;
               m_count = m_count + 16'd1;
            end else if (m_cnt != 0 && m_cnt < M_MAX) begin
               m_cnt = m_cnt + 24'd1;
               if (m_cnt == M_MAX) m_ovf = 1;
            end
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      seg = '0; enable = 1; clear = 0; rst = 1;
      tick(2);
      rst = 0;
   endtask

   typedef struct {
      logic [6:0]  seg;
      int          hold;
      logic [3:0]  digit;
      logic        dvalid;
      logic        inv;
      logic [15:0] count;
   } vec_t;

   vec_t vecs [8];

   initial begin
      int hold;
      vecs[0] = '{7'h3F, 10, 4'd0, 1'b1, 1'b0, 16'd1};
      vecs[1] = '{7'h00, 10, 4'd0, 1'b0, 1'b0, 16'd1};
      vecs[2] = '{7'h06, 10, 4'd1, 1'b1, 1'b0, 16'd2};
      vecs[3] = '{7'h00, 10, 4'd1, 1'b0, 1'b0, 16'd2};
      vecs[4] = '{7'h49, 10, 4'd1, 1'b0, 1'b1, 16'd2};
      vecs[5] = '{7'h7F, 10, 4'd8, 1'b1, 1'b1, 16'd3};
      vecs[6] = '{7'h6F, 10, 4'd9, 1'b1, 1'b1, 16'd4};
      vecs[7] = '{7'h4F, 10, 4'd3, 1'b1, 1'b1, 16'd5};

      // Reset state
      do_reset();
      check("reset_outputs", {digit, dvalid, change, interval, ivalid, count, inv, ovf}, '0);

      // Exact acceptance latency: edge S+2 after the change
      seg = 7'h3F;
      tick(S + 1);
      check("latency_before_pulse", {change, dvalid}, 2'b00);
      tick(1);
      check("latency_pulse", {change, dvalid, digit}, {1'b1, 1'b1, 4'd0});
      check("latency_count", count, 16'd1);
      check("latency_ivalid", ivalid, 1'b0);
      tick(1);
      check("pulse_one_cycle", change, 1'b0);

      // Table vectors
      do_reset();
      foreach (vecs[i]) begin
         seg = vecs[i].seg;
         tick(vecs[i].hold);
         check($sformatf("vec%0d_digit", i), digit, vecs[i].digit);
         check($sformatf("vec%0d_dvalid", i), dvalid, vecs[i].dvalid);
         check($sformatf("vec%0d_invalid", i), inv, vecs[i].inv);
         check($sformatf("vec%0d_count", i), count, vecs[i].count);
      end

      // Changes exactly 1000 cycles apart
      do_reset();
      seg = 7'h06; tick(1000);
      check("iv_first_ivalid", {ivalid, digit}, {1'b0, 4'd1});
      seg = 7'h5B; tick(1000);
      check("iv_second", {ivalid, interval, digit}, {1'b1, 24'd1000, 4'd2});
      seg = 7'h4F; tick(10);
      check("iv_third", {count, interval, digit}, {16'd3, 24'd1000, 4'd3});

      // Saturation on the 8-bit instance, 300 cycles apart
      do_reset();
      seg = 7'h06; tick(300);
      seg = 7'h5B; tick(300);
      check("small_interval_sat", {s_interval, s_ovf, s_ivalid}, {8'd255, 1'b1, 1'b1});
      check("wide_interval_300", {interval, ovf}, {24'd300, 1'b0});

      // Glitch rejection and acceptance
      do_reset();
      seg = 7'h6D; tick(10);
      seg = 7'h7D; tick(3);
      seg = 7'h6D; tick(10);
      check("glitch3_rejected", {digit, count}, {4'd5, 16'd1});
      seg = 7'h7D; tick(4);
      seg = 7'h6D; tick(2);
      check("glitch4_accepted", {digit, count, change}, {4'd6, 16'd2, 1'b1});
      tick(10);
      check("glitch4_return", {digit, count}, {4'd5, 16'd3});

      // Clear on the exact acceptance edge
      do_reset();
      seg = 7'h7F; tick(10);
      seg = 7'h66; tick(S + 1);
      clear = 1; tick(1);
      check("clear_on_accept", {digit, dvalid, change, interval, ivalid, count, inv, ovf}, '0);
      clear = 0;

      // Enable low across a pattern change
      do_reset();
      seg = 7'h07; tick(10);
      enable = 0;
      seg = 7'h7F; tick(20);
      check("disabled_hold", {digit, count, change}, {4'd7, 16'd1, 1'b0});
      enable = 1; tick(S - 1);
      check("reenable_wait", {digit, count}, {4'd7, 16'd1});
      tick(1);
      check("reenable_accept", {digit, count, change}, {4'd8, 16'd2, 1'b1});

      // Randomized run against the reference model
      do_reset();
      hold = 0;
      for (int c = 0; c < 4000; c++) begin
         int r;
         if (hold == 0) begin
            r = $urandom_range(0, 15);
            if (r < 10) seg = seg_tab[r];
            else if (r < 12) seg = 7'h00;
            else seg = 7'($urandom);
            hold = $urandom_range(1, 9);
         end
         hold--;
         enable = ($urandom_range(0, 15) != 0);
         clear  = ($urandom_range(0, 199) == 0);
         rst    = ($urandom_range(0, 499) == 0);
         tick(1);
         check("rand_cycle",
               {digit, dvalid, change, interval, ivalid, count, inv, ovf},
               {m_digit, m_dvalid, m_change, m_interval, m_ivalid, m_count, m_inv, m_ovf});
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
